// File: rtl/sc_levelcounter_comparator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sc_levelcounter_comparator_pkg
// Brief    : Level-count defaults shared with the general game state machine.
// Revision : 1.0 - initial release
// ============================================================================
package sc_levelcounter_comparator_pkg;

   localparam int c_LEVEL_W     = 3;
   localparam int c_MAX_LEVEL   = 4;
   localparam int c_PRESC_W     = 24;
   localparam int c_BASE_PERIOD = 10;
   localparam int c_STEP        = 2;

endpackage
`default_nettype wire

// File: rtl/sc_levelcounter_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : sc_levelcounter_prescaler
// Brief    : Free-running period counter with restart and a registered tick.
// Revision : 1.0 - initial release
// ============================================================================
module sc_levelcounter_prescaler
   import sc_levelcounter_comparator_pkg::*;
#(
   parameter int PRESC_W = c_PRESC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PRESC_W-1:0] period,
   input  logic               restart,
   output logic               tick
);

   logic [PRESC_W-1:0] r_count;
   logic               r_tick;
   logic               w_last;

   assign w_last = (r_count == (period - PRESC_W'(1)));

   // Restart wins over a terminal count so the old period never ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_tick  <= 1'b0;
      end else if (restart) begin
         r_count <= '0;
         r_tick  <= 1'b0;
      end else if (w_last) begin
         r_count <= '0;
         r_tick  <= 1'b1;
      end else begin
         r_count <= r_count + PRESC_W'(1);
         r_tick  <= 1'b0;
      end
   end

   assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/sc_levelcounter_comparator.sv
`default_nettype none
// ============================================================================
// Module   : sc_levelcounter_comparator
// Brief    : Level register, max-level comparator and level-scaled speed tick.
//            Define SC_LEVELCOUNTER_WRAP_EN to wrap past MAX_LEVEL to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sc_levelcounter_comparator
   import sc_levelcounter_comparator_pkg::*;
#(
   parameter int LEVEL_W     = c_LEVEL_W,
   parameter int MAX_LEVEL   = c_MAX_LEVEL,
   parameter int PRESC_W     = c_PRESC_W,
   parameter int BASE_PERIOD = c_BASE_PERIOD,
   parameter int STEP        = c_STEP
) (
   input  logic               SC_LEVELCOUNTER_CLOCK_50,
   input  logic               SC_LEVELCOUNTER_RESET_InHigh,
   input  logic               SC_LEVELCOUNTER_upcount_InLow,
   input  logic               SC_LEVELCOUNTER_clear_InLow,
   output logic [LEVEL_W-1:0] SC_LEVELCOUNTER_level_Out,
   output logic               SC_LEVELCOUNTER_COMPARATOR_LEVELS_Out,
   output logic               SC_LEVELCOUNTER_levelup_Out,
   output logic               SC_LEVELCOUNTER_tick_Out
);

   generate
      if (BASE_PERIOD <= MAX_LEVEL * STEP) begin : g_bad_period
         $error("BASE_PERIOD must exceed MAX_LEVEL*STEP");
      end
      if (MAX_LEVEL >= (1 << LEVEL_W)) begin : g_bad_level_w
         $error("MAX_LEVEL does not fit in LEVEL_W bits");
      end
   endgenerate

   logic               r_prev;
   logic [LEVEL_W-1:0] r_level;
   logic               r_levelup;
   logic               w_adv;
   logic               w_at_max;
   logic               w_step;
   logic [LEVEL_W-1:0] w_next_level;
   logic               w_restart;
   logic [PRESC_W-1:0] w_period;

   assign w_adv    = ~SC_LEVELCOUNTER_upcount_InLow & r_prev;
   assign w_at_max = (r_level == LEVEL_W'(MAX_LEVEL));

`ifdef SC_LEVELCOUNTER_WRAP_EN
   assign w_step       = w_adv;
   assign w_next_level = w_at_max ? '0 : r_level + LEVEL_W'(1);
`else
   assign w_step       = w_adv & ~w_at_max;
   assign w_next_level = r_level + LEVEL_W'(1);
`endif

   // prev keeps sampling during clear so a held-low advance is consumed.
   always_ff @(posedge SC_LEVELCOUNTER_CLOCK_50 or posedge SC_LEVELCOUNTER_RESET_InHigh) begin
      if (SC_LEVELCOUNTER_RESET_InHigh) begin
         r_prev    <= 1'b1;
         r_level   <= '0;
         r_levelup <= 1'b0;
      end else begin
         r_prev    <= SC_LEVELCOUNTER_upcount_InLow;
         r_levelup <= 1'b0;
         if (!SC_LEVELCOUNTER_clear_InLow) begin
            r_level <= '0;
         end else if (w_step) begin
            r_level   <= w_next_level;
            r_levelup <= 1'b1;
         end
      end
   end

   assign w_restart = ~SC_LEVELCOUNTER_clear_InLow | w_step;
   assign w_period  = PRESC_W'(BASE_PERIOD) - (PRESC_W'(r_level) * PRESC_W'(STEP));

   sc_levelcounter_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_prescaler (
      .clk     (SC_LEVELCOUNTER_CLOCK_50),
      .rst     (SC_LEVELCOUNTER_RESET_InHigh),
      .period  (w_period),
      .restart (w_restart),
      .tick    (SC_LEVELCOUNTER_tick_Out)
   );

   assign SC_LEVELCOUNTER_level_Out             = r_level;
   assign SC_LEVELCOUNTER_levelup_Out           = r_levelup;
   assign SC_LEVELCOUNTER_COMPARATOR_LEVELS_Out = w_at_max;

endmodule
`default_nettype wire

// File: tb/tb_sc_levelcounter_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_levelcounter_comparator
// Brief    : Scoreboard bench: driver queues expected levelup/tick events,
//            an independent monitor matches them against DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_levelcounter_comparator;

   localparam int MAXL = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       upc = 1'b1;
   logic       clr = 1'b1;
   logic [2:0] level;
   logic       comp;
   logic       lu;
   logic       tick;

   int cyc   = 0;
   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b0;

   typedef struct {
      bit is_tick;
      int c;
      int lvl;
   } ev_t;

   ev_t exp_q[$];

   sc_levelcounter_comparator dut (
      .SC_LEVELCOUNTER_CLOCK_50              (clk),
      .SC_LEVELCOUNTER_RESET_InHigh          (rst),
      .SC_LEVELCOUNTER_upcount_InLow         (upc),
      .SC_LEVELCOUNTER_clear_InLow           (clr),
      .SC_LEVELCOUNTER_level_Out             (level),
      .SC_LEVELCOUNTER_COMPARATOR_LEVELS_Out (comp),
      .SC_LEVELCOUNTER_levelup_Out           (lu),
      .SC_LEVELCOUNTER_tick_Out              (tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int c);
      while (cyc < c) step();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input bit is_tick, input int c, input int lvl);
      ev_t e;
      e.is_tick = is_tick;
      e.c       = c;
      e.lvl     = lvl;
      exp_q.push_back(e);
   endtask

   task automatic close_window(input string name);
      mon_en = 1'b0;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_missing: %0d expected events never seen, first due cycle %0d, required 0 left",
                  name, exp_q.size(), exp_q[0].c);
         exp_q.delete();
      end
   endtask

   task automatic check_ev(input bit is_tick);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event: got %s at cycle %0d level %0d, required no event",
                  is_tick ? "tick" : "levelup", cyc, level);
      end else begin
         e = exp_q.pop_front();
         if (e.is_tick != is_tick || e.c != cyc || int'(level) != e.lvl ||
             comp !== ((e.lvl == MAXL) ? 1'b1 : 1'b0)) begin
            fails++;
            $display("FAIL event: got %s@%0d level %0d comp %b, required %s@%0d level %0d",
                     is_tick ? "tick" : "levelup", cyc, level, comp,
                     e.is_tick ? "tick" : "levelup", e.c, e.lvl);
         end
      end
   endtask

   // Monitor: every asserted pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (lu === 1'b1)   check_ev(1'b0);
         if (tick === 1'b1) check_ev(1'b1);
      end
   end

   initial begin
      int k;

      // Reset state
      step();
      chk("reset_level", 32'(level), 0);
      chk("reset_comp", 32'(comp), 0);
      chk("reset_levelup", 32'(lu), 0);
      chk("reset_tick", 32'(tick), 0);
      step();
      rst = 1'b0;
      step();
      step();

      // Level 0 free run (period 10), then advance at counter 7 and hold low
      k = cyc;
      clr = 1'b0;
      step();
      clr = 1'b1;
      push(1, k + 11, 0);
      push(1, k + 21, 0);
      push(1, k + 31, 0);
      push(0, k + 39, 1);
      push(1, k + 47, 1);
      push(1, k + 55, 1);
      mon_en = 1'b1;
      goto(k + 38);
      upc = 1'b0;
      goto(k + 58);
      upc = 1'b1;
      chk("hold_low_level", 32'(level), 1);
      goto(k + 61);
      close_window("run_and_hold");

      // Four pulses to MAX_LEVEL, then a fifth pulse
      k = cyc;
      clr = 1'b0;
      step();
      clr = 1'b1;
      push(0, k + 3, 1);
      push(0, k + 5, 2);
      push(0, k + 7, 3);
      push(0, k + 9, 4);
      push(1, k + 11, 4);
      push(1, k + 13, 4);
`ifdef SC_LEVELCOUNTER_WRAP_EN
      push(0, k + 15, 0);
`else
      for (int t = 15; t <= 23; t += 2) push(1, k + t, 4);
`endif
      mon_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         goto(k + 2 + 2 * i);
         upc = 1'b0;
         step();
         upc = 1'b1;
      end
      goto(k + 10);
      chk("max_level", 32'(level), 4);
      chk("max_comp", 32'(comp), 1);
      goto(k + 14);
      upc = 1'b0;
      step();
      upc = 1'b1;
      goto(k + 20);
`ifdef SC_LEVELCOUNTER_WRAP_EN
      chk("fifth_pulse_level", 32'(level), 0);
      chk("fifth_pulse_comp", 32'(comp), 0);
`else
      chk("fifth_pulse_level", 32'(level), 4);
      chk("fifth_pulse_comp", 32'(comp), 1);
`endif
      goto(k + 25);
      close_window("saturate");

      // Clear together with an advance edge at level 3
      k = cyc;
      clr = 1'b0;
      step();
      clr = 1'b1;
      push(0, k + 3, 1);
      push(0, k + 5, 2);
      push(0, k + 7, 3);
      push(1, k + 20, 0);
      mon_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         goto(k + 2 + 2 * i);
         upc = 1'b0;
         step();
         upc = 1'b1;
      end
      goto(k + 8);
      upc = 1'b0;
      clr = 1'b0;
      step();
      chk("clear_priority_level", 32'(level), 0);
      step();
      upc = 1'b1;
      clr = 1'b1;
      goto(k + 12);
      chk("after_release_level", 32'(level), 0);
      goto(k + 23);
      close_window("clear_priority");

      // Asynchronous reset mid-cycle at level 2
      k = cyc;
      for (int i = 0; i < 2; i++) begin
         goto(k + 1 + 2 * i);
         upc = 1'b0;
         step();
         upc = 1'b1;
      end
      chk("pre_reset_level", 32'(level), 2);
      chk("pre_reset_levelup", 32'(lu), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_level", 32'(level), 0);
      chk("async_reset_levelup", 32'(lu), 0);
      chk("async_reset_tick", 32'(tick), 0);
      chk("async_reset_comp", 32'(comp), 0);
      step();
      rst = 1'b0;
      step();
      chk("post_reset_level", 32'(level), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
